// File: rtl/qif_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | qif_pkg : shared defaults and saturating add for the QIF spike link |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package qif_pkg;

  localparam int WINDOW_DEF = 256;
  localparam int CNT_W_DEF  = 8;
  localparam int ISI_W_DEF  = 16;

  // Widths up to 31 bits; callers cast the result back to their own width.
  function automatic logic [31:0] sat_add(input logic [31:0] val,
                                          input logic [31:0] inc,
                                          input logic [31:0] max_val);
    logic [32:0] sum;
    sum = {1'b0, val} + {1'b0, inc};
    return (sum > {1'b0, max_val}) ? max_val : sum[31:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/spike_edge_detect.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | spike_edge_detect : rising-edge detector on the spike level line    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module spike_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q_rise
);

  logic r_d_q;

  // Tracks the line unconditionally so a level already high when counting resumes is not an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_d_q <= 1'b0;
    else     r_d_q <= d;
  end

  assign q_rise = d & ~r_d_q;

endmodule
`default_nettype wire

// File: rtl/spike_rate_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | spike_rate_decoder : windowed spike rate and inter-spike interval   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module spike_rate_decoder
  import qif_pkg::*;
#(
  parameter int WINDOW = WINDOW_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int ISI_W  = ISI_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             spike_in,
  output logic [CNT_W-1:0] rate_out,
  output logic             rate_valid,
  input  logic             rate_ready,
  output logic [ISI_W-1:0] isi_out,
  output logic             isi_valid,
  output logic             overrun
);

  localparam int                 c_win_w    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [c_win_w-1:0] c_win_last = c_win_w'(WINDOW - 1);
  localparam logic [31:0]        c_cnt_max  = (32'd1 << CNT_W) - 32'd1;
  localparam logic [31:0]        c_isi_max  = (32'd1 << ISI_W) - 32'd1;

  logic               w_rise;
  logic               w_hit;
  logic               w_close;
  logic [CNT_W-1:0]   w_count_next;
  logic [ISI_W-1:0]   w_interval_next;

  logic [c_win_w-1:0] r_win_cnt;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   r_rate;
  logic               r_rate_valid;
  logic               r_overrun;
  logic [ISI_W-1:0]   r_interval;
  logic               r_armed;
  logic [ISI_W-1:0]   r_isi;
  logic               r_isi_valid;

  spike_edge_detect u_edge (
    .clk    (clk),
    .rst    (rst),
    .d      (spike_in),
    .q_rise (w_rise)
  );

  assign w_hit           = w_rise & en;
  assign w_close         = en & (r_win_cnt == c_win_last);
  assign w_count_next    = CNT_W'(sat_add(32'(r_count), 32'(w_hit), c_cnt_max));
  assign w_interval_next = ISI_W'(sat_add(32'(r_interval), 32'd1, c_isi_max));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_win_cnt <= '0;
      r_count   <= '0;
    end else if (en) begin
      r_win_cnt <= w_close ? '0 : r_win_cnt + c_win_w'(1);
      r_count   <= w_close ? '0 : w_count_next;
    end
  end

  // A close in the same cycle as a consume simply reloads; only an unread result counts as overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rate       <= '0;
      r_rate_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else if (w_close) begin
      r_rate       <= w_count_next;
      r_rate_valid <= 1'b1;
      if (r_rate_valid && !rate_ready) r_overrun <= 1'b1;
    end else if (r_rate_valid && rate_ready) begin
      r_rate_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_interval  <= '0;
      r_armed     <= 1'b0;
      r_isi       <= '0;
      r_isi_valid <= 1'b0;
    end else begin
      r_isi_valid <= 1'b0;
      if (w_hit) begin
        r_interval <= ISI_W'(1);
        r_armed    <= 1'b1;
        if (r_armed) begin
          r_isi       <= r_interval;
          r_isi_valid <= 1'b1;
        end
      end else if (en) begin
        r_interval <= w_interval_next;
      end
    end
  end

  assign rate_out   = r_rate;
  assign rate_valid = r_rate_valid;
  assign overrun    = r_overrun;
  assign isi_out    = r_isi;
  assign isi_valid  = r_isi_valid;

endmodule
`default_nettype wire
